// File: rtl/call_button_conditioner.sv
// Per-channel call-button conditioner: synchronize, debounce, emit a single gated
// T pulse per accepted press, and flag buttons held beyond STUCK_CYCLES.
module call_button_conditioner #(
  parameter int NUM_BTN      = 4,
  parameter int DB_CYCLES    = 16,
  parameter int STUCK_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               enable,
  output logic [NUM_BTN-1:0] T,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] stuck
);

  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int HOLD_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STUCK_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    state_t              r_state;
    state_t              w_next;
    logic [DB_W-1:0]     r_db_cnt;
    logic [DB_W-1:0]     w_db_cnt_nxt;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic                w_sync;
    logic                w_t_nxt;
    logic                w_level_nxt;
    logic                w_stuck_nxt;
    logic                r_t;
    logic                r_level;
    logic                r_stuck;

    assign w_sync = r_sync2[g];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state  <= IDLE;
        r_db_cnt <= '0;
      end else begin
        r_state  <= w_next;
        r_db_cnt <= w_db_cnt_nxt;
      end
    end

    always_comb begin
      w_next       = r_state;
      w_db_cnt_nxt = r_db_cnt;
      case (r_state)
        IDLE: begin
          if (w_sync) begin
            w_next       = PRESS_WAIT;
            w_db_cnt_nxt = '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_sync)                w_next = IDLE;
          else if (r_db_cnt == DB_LAST) w_next = HELD;
          else                        w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
        HELD: begin
          if (!w_sync) begin
            w_next       = RELEASE_WAIT;
            w_db_cnt_nxt = '0;
          end
        end
        RELEASE_WAIT: begin
          if (w_sync)                 w_next = HELD;
          else if (r_db_cnt == DB_LAST) w_next = IDLE;
          else                        w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
        default: w_next = IDLE;
      endcase
    end

    // Outputs are computed from the transition and registered, so T and btn_level rise together.
    always_comb begin
      w_t_nxt     = (r_state == PRESS_WAIT) && (w_next == HELD) && enable;
      w_level_nxt = (w_next == HELD) || (w_next == RELEASE_WAIT);
      w_hold_nxt  = r_hold;
      if (w_next == IDLE)
        w_hold_nxt = '0;
      else if (((r_state == HELD) || (r_state == RELEASE_WAIT)) && (r_hold != HOLD_MAX))
        w_hold_nxt = r_hold + 1'b1;
      w_stuck_nxt = (w_hold_nxt == HOLD_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_hold  <= '0;
        r_t     <= 1'b0;
        r_level <= 1'b0;
        r_stuck <= 1'b0;
      end else begin
        r_hold  <= w_hold_nxt;
        r_t     <= w_t_nxt;
        r_level <= w_level_nxt;
        r_stuck <= w_stuck_nxt;
      end
    end

    assign T[g]         = r_t;
    assign btn_level[g] = r_level;
    assign stuck[g]     = r_stuck;
  end

endmodule

// File: tb/tb_call_button_conditioner.sv
// Directed bench for call_button_conditioner with DB_CYCLES=4, STUCK_CYCLES=20, NUM_BTN=4.
module tb_call_button_conditioner;

  logic       clk;
  logic       reset;
  logic [3:0] btn_raw;
  logic       enable;
  logic [3:0] T;
  logic [3:0] btn_level;
  logic [3:0] stuck;

  int n_checks;
  int n_errors;
  int bad;
  int pulses;
  int at;

  call_button_conditioner #(
    .NUM_BTN(4),
    .DB_CYCLES(4),
    .STUCK_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .enable(enable),
    .T(T),
    .btn_level(btn_level),
    .stuck(stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Each step returns at the falling edge following one rising edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    btn_raw  = 4'b0000;
    enable   = 1'b1;
    step(2);
    chk("rst_T", 32'(T), 32'h0);
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_stuck", 32'(stuck), 32'h0);
    reset = 1'b0;
    step(2);

    // Clean press on channel 0, held 30 cycles
    btn_raw = 4'b0001;
    step(6);
    chk("clean_T_early", 32'(T), 32'h0);
    chk("clean_level_early", 32'(btn_level), 32'h0);
    step(1);
    chk("clean_T_edge7", 32'(T), 32'h1);
    chk("clean_level_edge7", 32'(btn_level), 32'h1);
    step(1);
    chk("clean_T_edge8", 32'(T), 32'h0);
    bad = 0;
    for (int k = 0; k < 22; k++) begin
      step(1);
      if (T != 4'b0000) bad++;
    end
    chk("clean_single_pulse", 32'(bad), 32'h0);
    btn_raw = 4'b0000;
    step(10);
    chk("clean_release_level", 32'(btn_level), 32'h0);
    chk("clean_release_stuck", 32'(stuck), 32'h0);

    // Bounce on channel 1: toggles every 2 cycles for 12 cycles, then held
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      btn_raw[1] = ((c % 2) == 0);
      for (int k = 0; k < 2; k++) begin
        step(1);
        if ((T != 4'b0000) || (btn_level != 4'b0000)) bad++;
      end
    end
    chk("bounce_glitch", 32'(bad), 32'h0);
    btn_raw[1] = 1'b1;
    pulses = 0;
    at     = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (T[1]) begin
        pulses++;
        at = k;
      end
    end
    chk("bounce_pulses", 32'(pulses), 32'h1);
    chk("bounce_latency", 32'(at), 32'h7);
    chk("bounce_level", 32'(btn_level), 32'h2);
    btn_raw = 4'b0000;
    step(10);

    // Gated press on channel 2
    enable     = 1'b0;
    btn_raw[2] = 1'b1;
    step(7);
    chk("gated_T", 32'(T), 32'h0);
    chk("gated_level", 32'(btn_level), 32'h4);
    step(1);
    enable = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (T != 4'b0000) bad++;
    end
    chk("gated_no_deferred", 32'(bad), 32'h0);
    btn_raw = 4'b0000;
    step(10);
    chk("gated_release_level", 32'(btn_level), 32'h0);

    // Stuck detection on channel 3
    btn_raw[3] = 1'b1;
    step(26);
    chk("stuck_edge26", 32'(stuck), 32'h0);
    step(1);
    chk("stuck_edge27", 32'(stuck), 32'h8);
    step(13);
    chk("stuck_held", 32'(stuck), 32'h8);
    btn_raw = 4'b0000;
    step(6);
    chk("stuck_release_wait", 32'(stuck), 32'h8);
    chk("stuck_release_level", 32'(btn_level), 32'h8);
    step(1);
    chk("stuck_idle_clear", 32'(stuck), 32'h0);
    chk("stuck_idle_level", 32'(btn_level), 32'h0);
    step(4);

    // Reset during PRESS_WAIT, button held across deassertion
    btn_raw = 4'b0001;
    step(4);
    reset = 1'b1;
    #1;
    chk("rst_pw_T", 32'(T), 32'h0);
    chk("rst_pw_level", 32'(btn_level), 32'h0);
    step(2);
    reset = 1'b0;
    step(6);
    chk("rst_fresh_T_early", 32'(T), 32'h0);
    step(1);
    chk("rst_fresh_T_edge7", 32'(T), 32'h1);
    step(1);
    chk("rst_fresh_T_edge8", 32'(T), 32'h0);
    step(3);
    // Reset while held must drop the level at once
    reset = 1'b1;
    #1;
    chk("rst_held_level", 32'(btn_level), 32'h0);
    btn_raw = 4'b0000;
    step(2);
    reset = 1'b0;
    step(3);

    // Simultaneous press on all channels
    btn_raw = 4'b1111;
    step(6);
    chk("simul_T_early", 32'(T), 32'h0);
    step(1);
    chk("simul_T_edge7", 32'(T), 32'hF);
    chk("simul_level", 32'(btn_level), 32'hF);
    step(1);
    chk("simul_T_edge8", 32'(T), 32'h0);
    btn_raw = 4'b0000;
    step(10);
    chk("simul_release", 32'(btn_level), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/call_button_conditioner.md
CALL_BUTTON_CONDITIONER -- requirements
Module: call_button_conditioner

Interface
REQ-001 Parameter NUM_BTN, default 4: number of independent call-button channels.
REQ-002 Parameter DB_CYCLES, default 16: consecutive stable clk cycles required to accept a press or a release; minimum 2.
REQ-003 Parameter STUCK_CYCLES, default 1000: debounced-held clk cycles after which a button is flagged stuck; must exceed DB_CYCLES.
REQ-004 clk  input  1  system clock; all state is updated on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_raw  input  NUM_BTN  raw, asynchronous, bouncing call buttons; 1 = pressed.
REQ-007 enable  input  1  synchronous pulse gate; 0 suppresses T pulses.
REQ-008 T  output  NUM_BTN  registered single-cycle press pulses, one per channel; each bit drives one downstream toggle flip-flop's T input.
REQ-009 btn_level  output  NUM_BTN  registered debounced button level.
REQ-010 stuck  output  NUM_BTN  registered flag; 1 = button debounced-held for at least STUCK_CYCLES cycles.

Function
REQ-011 Each channel shall pass btn_raw[i] through a two-flop synchronizer; only the second flop (sync[i]) is used downstream.
REQ-012 Each channel shall have its own 4-state FSM (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), its own debounce counter of width clog2(DB_CYCLES), and its own hold counter of width clog2(STUCK_CYCLES+1).
REQ-013 IDLE: on sync=1, go to PRESS_WAIT and clear the debounce counter; otherwise stay in IDLE.
REQ-014 PRESS_WAIT: on sync=0, go to IDLE.
REQ-015 PRESS_WAIT: while sync=1, increment the counter; when counter==DB_CYCLES-1 and sync=1, go to HELD.
REQ-016 HELD: on sync=0, go to RELEASE_WAIT and clear the debounce counter.
REQ-017 RELEASE_WAIT: on sync=1, return to HELD with no new pulse.
REQ-018 RELEASE_WAIT: while sync=0, increment the counter; when counter==DB_CYCLES-1, go to IDLE.
REQ-019 The PRESS_WAIT->HELD transition shall set T[i]=1 for exactly one cycle if enable=1 in that same cycle; otherwise no pulse is produced, and none is deferred.
REQ-020 Latency: with btn_raw[i] rising before edge 1 and held stable, T[i] shall be high from edge DB_CYCLES+3 to edge DB_CYCLES+4.
REQ-021 btn_level[i] shall be 1 exactly when the state is HELD or RELEASE_WAIT, registered, and aligned with T[i] on assertion.
REQ-022 Any high or low excursion of sync lasting fewer than DB_CYCLES cycles shall produce no T pulse and no btn_level change.
REQ-023 The hold counter shall count cycles spent in HELD or RELEASE_WAIT, saturating at STUCK_CYCLES.
REQ-024 stuck[i] shall be set when the hold counter reaches STUCK_CYCLES, and cleared, together with the hold counter, on entry to IDLE.
REQ-025 Channels shall be fully independent; several T bits may assert in the same cycle.
REQ-026 A pressed button shall generate at most one T pulse until it has been debounced-released (back to IDLE) and debounced-pressed again.

Reset
REQ-027 While reset=1: synchronizers=0, all FSMs=IDLE, all counters=0, T=0, btn_level=0, stuck=0, independent of clk.
REQ-028 Reset asserted mid-debounce or mid-hold shall abort the channel with no pulse.
REQ-029 A button held across reset deassertion shall be treated as a fresh press and pulse DB_CYCLES+3 edges after reset falls.

Verification (DB_CYCLES=4, STUCK_CYCLES=20, NUM_BTN=4)
REQ-030 Clean press: btn_raw[0] 0->1, held 30 cycles -> T[0] high for one cycle at edge 7, btn_level[0]=1 from edge 7, T[3:1]=0.
REQ-031 Bounce: btn_raw[1] toggles every 2 cycles for 12 cycles, then held 1 -> exactly one T[1] pulse, occurring 7 edges after the final rising transition.
REQ-032 Gated press: enable=0 during the HELD transition of btn_raw[2] -> T[2] stays 0 and btn_level[2]=1; raising enable later produces no pulse.
REQ-033 Stuck: btn_raw[3] held 40 cycles -> stuck[3]=1 by edge 27; release -> stuck[3]=0 once the FSM reaches IDLE.
REQ-034 Reset: reset pulsed during PRESS_WAIT -> all outputs 0 immediately; btn_raw held after reset falls -> one pulse 7 edges later.
REQ-035 Simultaneous: btn_raw=4'b1111 on the same edge -> T=4'b1111 for one cycle at edge 7.
